// File: rtl/configf_pkg.sv
// Shared constants and types for the multi-channel config host.
package configf_pkg;

    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_NUM_W       = 16;
    localparam int unsigned DEF_HOLD_CYC    = 15;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_EXEC  = 4'b0100,
        S_HOLD  = 4'b1000
    } state_e;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/configf_rr_arb.sv
// Round-robin grant search starting just after the last granted channel.
module configf_rr_arb #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [IDX_W-1:0]  grant_o,
    output logic              valid_o
);

    // Scan farthest-first so the nearest requester after last_i wins.
    always_comb begin : scan
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            idx = (32'(last_i) + k) % NUM_CH;
            if (req_i[IDX_W'(idx)]) begin
                grant_o = IDX_W'(idx);
            end
        end
    end

    assign valid_o = advance_i & (|req_i);

endmodule

// File: rtl/configf_host_mc.sv
// Arbitrates NUM_CH user command ports onto the single configf_entity command port,
// one command in flight, with post-done hold window and command timeout.
module configf_host_mc
    import configf_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NUM_W       = DEF_NUM_W,
    parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        usr_cmd_en_in,
    input  logic [NUM_CH*ADDR_W-1:0] usr_addr_in,
    input  logic [NUM_CH*NUM_W-1:0]  usr_wrrd_num_in,
    output logic [NUM_CH-1:0]        usr_cmd_done_out,
    output logic [NUM_CH-1:0]        usr_cmd_err_out,
    input  logic                     ent_cmd_done_in,
    output logic                     ent_cmd_en_out,
    output logic [ADDR_W-1:0]        ent_addr_out,
    output logic [NUM_W-1:0]         ent_wrrd_num_out,
    output logic                     busy_out
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYC);
    localparam int unsigned HLD_W = cnt_w(HOLD_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);
    localparam logic [HLD_W-1:0] HLD_MAX  = {HLD_W{1'b1}};

    state_e state_q, state_d;

    logic [NUM_CH-1:0] en_q, pend_q, pend_d;
    logic [IDX_W-1:0]  last_q, last_d, gidx_q, gidx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [HLD_W-1:0]  hold_q, hold_d;
    logic              early_q, early_d, err_q, err_d;

    logic [NUM_CH-1:0] done_d, errp_d;
    logic              ent_en_d, busy_d;
    logic [ADDR_W-1:0] ent_addr_d;
    logic [NUM_W-1:0]  ent_num_d;

    logic [NUM_CH-1:0] rise, req;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld, tmo_hit, in_cmd, fire;

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [NUM_W-1:0]  num_arr  [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i] = usr_addr_in[i*ADDR_W +: ADDR_W];
        assign num_arr[i]  = usr_wrrd_num_in[i*NUM_W +: NUM_W];
    end

    assign rise    = usr_cmd_en_in & ~en_q;
    assign req     = pend_q | rise;
    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q >= TMO_LAST);

    configf_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req_i     (req),
        .advance_i (state_q == S_IDLE),
        .last_i    (last_q),
        .grant_o   (arb_idx),
        .valid_o   (arb_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Done outranks a same-cycle timeout; a done seen during ISSUE is remembered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_EXEC;
            S_EXEC:  if (ent_cmd_done_in || early_q || tmo_hit) state_d = S_HOLD;
            S_HOLD:  if (hold_q == HLD_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pend_d  = pend_q | rise;
        last_d  = last_q;
        gidx_d  = gidx_q;
        addr_d  = addr_q;
        num_d   = num_q;
        tmo_d   = tmo_q;
        early_d = early_q;
        err_d   = err_q;
        hold_d  = '0;

        if (state_q == S_IDLE && arb_vld) begin
            pend_d[arb_idx] = 1'b0;
            gidx_d  = arb_idx;
            last_d  = arb_idx;
            addr_d  = addr_arr[arb_idx];
            num_d   = num_arr[arb_idx];
            tmo_d   = '0;
            early_d = 1'b0;
            err_d   = 1'b0;
        end
        if ((state_q == S_ISSUE || state_q == S_EXEC) && tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (state_q == S_ISSUE && ent_cmd_done_in) early_d = 1'b1;
        if (state_q == S_EXEC && state_d == S_HOLD) err_d = ~(ent_cmd_done_in | early_q);
        if (state_q == S_HOLD) hold_d = (hold_q == HLD_MAX) ? hold_q : hold_q + HLD_W'(1);

        // Output registers load from next-state values so they line up with the state.
        in_cmd     = (state_d == S_ISSUE) || (state_d == S_EXEC);
        ent_en_d   = (state_d == S_ISSUE);
        ent_addr_d = in_cmd ? addr_d : '0;
        ent_num_d  = in_cmd ? num_d : '0;
        busy_d     = (state_d != S_IDLE);
        fire       = (state_d == S_HOLD) && (hold_d == HLD_LAST);
        done_d     = '0;
        errp_d     = '0;
        if (fire) begin
            if (err_d) errp_d[gidx_d] = 1'b1;
            else       done_d[gidx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q             <= '0;
            pend_q           <= '0;
            last_q           <= '0;
            gidx_q           <= '0;
            addr_q           <= '0;
            num_q            <= '0;
            tmo_q            <= '0;
            hold_q           <= '0;
            early_q          <= 1'b0;
            err_q            <= 1'b0;
            usr_cmd_done_out <= '0;
            usr_cmd_err_out  <= '0;
            ent_cmd_en_out   <= 1'b0;
            ent_addr_out     <= '0;
            ent_wrrd_num_out <= '0;
            busy_out         <= 1'b0;
        end else begin
            en_q             <= usr_cmd_en_in;
            pend_q           <= pend_d;
            last_q           <= last_d;
            gidx_q           <= gidx_d;
            addr_q           <= addr_d;
            num_q            <= num_d;
            tmo_q            <= tmo_d;
            hold_q           <= hold_d;
            early_q          <= early_d;
            err_q            <= err_d;
            usr_cmd_done_out <= done_d;
            usr_cmd_err_out  <= errp_d;
            ent_cmd_en_out   <= ent_en_d;
            ent_addr_out     <= ent_addr_d;
            ent_wrrd_num_out <= ent_num_d;
            busy_out         <= busy_d;
        end
    end

endmodule

// File: tb/tb_configf_host_mc.sv
// Directed-plus-random bench for configf_host_mc against a transaction-level model
// (cyclic grant order, arithmetic strobe/pulse timing).
module tb_configf_host_mc;

    localparam int NCH  = 4;
    localparam int HOLD = 15;
    localparam int TMO  = 16;

    logic          clk;
    logic          reset;
    logic [3:0]    usr_cmd_en_in;
    logic [31:0]   usr_addr_in;
    logic [63:0]   usr_wrrd_num_in;
    logic [3:0]    usr_cmd_done_out;
    logic [3:0]    usr_cmd_err_out;
    logic          ent_cmd_done_in;
    logic          ent_cmd_en_out;
    logic [7:0]    ent_addr_out;
    logic [15:0]   ent_wrrd_num_out;
    logic          busy_out;

    configf_host_mc #(
        .NUM_CH(NCH), .ADDR_W(8), .NUM_W(16), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .usr_cmd_en_in    (usr_cmd_en_in),
        .usr_addr_in      (usr_addr_in),
        .usr_wrrd_num_in  (usr_wrrd_num_in),
        .usr_cmd_done_out (usr_cmd_done_out),
        .usr_cmd_err_out  (usr_cmd_err_out),
        .ent_cmd_done_in  (ent_cmd_done_in),
        .ent_cmd_en_out   (ent_cmd_en_out),
        .ent_addr_out     (ent_addr_out),
        .ent_wrrd_num_out (ent_wrrd_num_out),
        .busy_out         (busy_out)
    );

    typedef struct { int cyc; int addr; int num; } strobe_t;
    typedef struct { int cyc; int dn; int er; } pulse_t;

    strobe_t sq[$];
    pulse_t  pq[$];
    int cyc        = 0;
    int done_sched = -1;
    int done_force = -1;
    int resp_delay = 0;
    int addr_nz    = 0;
    int multi_hot  = 0;
    int n_total    = 0;
    int n_pass     = 0;
    int model_last = 0;
    logic [7:0]  addr_v [NCH];
    logic [15:0] num_v  [NCH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Entity responder: one-cycle done resp_delay cycles after each strobe, or a forced one.
    initial begin
        ent_cmd_done_in = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ent_cmd_done_in = (cyc == done_sched) || (cyc == done_force);
        end
    end

    always @(negedge clk) begin
        if (ent_cmd_en_out) begin
            sq.push_back(strobe_t'{cyc, int'(ent_addr_out), int'(ent_wrrd_num_out)});
            if (resp_delay > 0) done_sched = cyc + resp_delay;
        end
        if ((|usr_cmd_done_out) || (|usr_cmd_err_out))
            pq.push_back(pulse_t'{cyc, int'(usr_cmd_done_out), int'(usr_cmd_err_out)});
        if ($countones({usr_cmd_done_out, usr_cmd_err_out}) > 1) multi_hot++;
        if (ent_addr_out != 8'd0) addr_nz++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic rand_vals();
        for (int i = 0; i < NCH; i++) begin
            addr_v[i] = 8'($urandom_range(1, 255));
            num_v[i]  = 16'($urandom_range(1, 65535));
        end
    endtask

    task automatic drive_vals();
        for (int i = 0; i < NCH; i++) begin
            usr_addr_in[i*8 +: 8]      = addr_v[i];
            usr_wrrd_num_in[i*16 +: 16] = num_v[i];
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, longint'({usr_cmd_done_out, usr_cmd_err_out, ent_cmd_en_out, busy_out}), 0);
        chk({tag, "_addr"}, longint'(ent_addr_out), 0);
        chk({tag, "_num"}, longint'(ent_wrrd_num_out), 0);
    endtask

    // Raise all channels in mask together; model serves them in cyclic order after model_last,
    // each command taking strobe + d cycles of EXEC + HOLD window + one IDLE cycle.
    task automatic run_batch(input logic [3:0] mask, input int d, input string tag);
        int order[$];
        int t, s0, per, sb, pb, nb, ch;
        for (int k = 1; k <= NCH; k++) begin
            ch = (model_last + k) % NCH;
            if (mask[ch]) order.push_back(ch);
        end
        resp_delay = d;
        drive_vals();
        sb = sq.size(); pb = pq.size(); nb = addr_nz;
        t = cyc;
        usr_cmd_en_in = mask;
        s0  = t + 1;
        per = d + HOLD + 2;
        repeat (order.size() * per + 4) tick();
        usr_cmd_en_in = 4'b0;
        tick();
        chk($sformatf("%s_nstrobe", tag), sq.size() - sb, order.size());
        chk($sformatf("%s_npulse", tag), pq.size() - pb, order.size());
        for (int k = 0; k < order.size(); k++) begin
            if (sb + k < sq.size()) begin
                chk($sformatf("%s_s%0d_cyc", tag, k), sq[sb+k].cyc, s0 + k*per);
                chk($sformatf("%s_s%0d_addr", tag, k), sq[sb+k].addr, int'(addr_v[order[k]]));
                chk($sformatf("%s_s%0d_num", tag, k), sq[sb+k].num, int'(num_v[order[k]]));
            end
            if (pb + k < pq.size()) begin
                chk($sformatf("%s_p%0d_cyc", tag, k), pq[pb+k].cyc, s0 + k*per + d + HOLD);
                chk($sformatf("%s_p%0d_done", tag, k), pq[pb+k].dn, 1 << order[k]);
                chk($sformatf("%s_p%0d_err", tag, k), pq[pb+k].er, 0);
            end
        end
        chk($sformatf("%s_addr_valid_cycles", tag), addr_nz - nb, order.size() * (d + 1));
        if (order.size() > 0) model_last = order[order.size()-1];
    endtask

    // Single command on ch with entity response d (0 = never); ends in HOLD, timeout or done.
    task automatic run_single_tmo(input int ch, input int d, input bit expect_err, input string tag);
        int t, s, sb, pb, nb, pcyc;
        resp_delay = d;
        rand_vals();
        drive_vals();
        sb = sq.size(); pb = pq.size(); nb = addr_nz;
        t = cyc;
        usr_cmd_en_in = 4'(1 << ch);
        s = t + 1;
        repeat (TMO + HOLD + 6) tick();
        usr_cmd_en_in = 4'b0;
        tick();
        // ISSUE+EXEC last at most TMO cycles (s .. s+TMO-1); pulse closes the HOLD window.
        pcyc = s + TMO - 1 + HOLD;
        chk({tag, "_nstrobe"}, sq.size() - sb, 1);
        chk({tag, "_npulse"}, pq.size() - pb, 1);
        if (sq.size() > sb) chk({tag, "_s_cyc"}, sq[sb].cyc, s);
        if (pq.size() > pb) begin
            chk({tag, "_p_cyc"}, pq[pb].cyc, pcyc);
            chk({tag, "_p_done"}, pq[pb].dn, expect_err ? 0 : (1 << ch));
            chk({tag, "_p_err"}, pq[pb].er, expect_err ? (1 << ch) : 0);
        end
        chk({tag, "_addr_valid_cycles"}, addr_nz - nb, TMO);
        model_last = ch;
    endtask

    initial begin
        int d, t, s, sb, pb, ch, p1, s2;
        logic [3:0] mask;

        reset = 1'b1;
        usr_cmd_en_in = 4'b0;
        usr_addr_in = '0;
        usr_wrrd_num_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_idle_outputs("reset");

        // Single command on ch0, done 5 cycles after strobe.
        rand_vals();
        addr_v[0] = 8'h3C;
        num_v[0]  = 16'h0010;
        run_batch(4'b0001, 5, "single_ch0");

        // Three simultaneous requests after last grant 0.
        rand_vals();
        run_batch(4'b1110, int'($urandom_range(1, 8)), "rr_123");

        for (int it = 0; it < 4; it++) begin
            rand_vals();
            mask = 4'($urandom_range(1, 15));
            run_batch(mask, int'($urandom_range(1, 10)), $sformatf("rand%0d", it));
        end

        // Level held high for 100 cycles issues one command.
        rand_vals();
        drive_vals();
        d = int'($urandom_range(1, 8));
        resp_delay = d;
        sb = sq.size(); pb = pq.size();
        t = cyc;
        usr_cmd_en_in = 4'b0100;
        repeat (100) tick();
        usr_cmd_en_in = 4'b0;
        tick();
        s = t + 1;
        chk("held_nstrobe", sq.size() - sb, 1);
        chk("held_npulse", pq.size() - pb, 1);
        if (pq.size() > pb) begin
            chk("held_p_cyc", pq[pb].cyc, s + d + HOLD);
            chk("held_p_done", pq[pb].dn, 4);
        end
        model_last = 2;

        // Second rise on ch2 during HOLD is served right after returning to IDLE.
        sb = sq.size(); pb = pq.size();
        t = cyc;
        usr_cmd_en_in = 4'b0100;
        s = t + 1;
        repeat (d + 3) tick();
        usr_cmd_en_in = 4'b0;
        tick();
        usr_cmd_en_in = 4'b0100;
        p1 = s + d + HOLD;
        s2 = p1 + 2;
        repeat (2 * (d + HOLD + 2) + 4) tick();
        usr_cmd_en_in = 4'b0;
        tick();
        chk("rehold_nstrobe", sq.size() - sb, 2);
        chk("rehold_npulse", pq.size() - pb, 2);
        if (sq.size() > sb + 1) chk("rehold_s2_cyc", sq[sb+1].cyc, s2);
        if (pq.size() > pb + 1) begin
            chk("rehold_p1_cyc", pq[pb].cyc, p1);
            chk("rehold_p2_cyc", pq[pb+1].cyc, s2 + d + HOLD);
            chk("rehold_p2_done", pq[pb+1].dn, 4);
        end

        // Entity never answers: timeout error on the granted channel.
        run_single_tmo(int'($urandom_range(0, 3)), 0, 1'b1, "timeout");

        // Done lands on the timeout cycle: resolves as done.
        run_single_tmo(int'($urandom_range(0, 3)), TMO - 1, 1'b0, "done_at_tmo");

        // Done while IDLE is ignored.
        resp_delay = 0;
        sb = sq.size(); pb = pq.size();
        done_force = cyc + 2;
        repeat (HOLD + 10) tick();
        chk("idle_done_nstrobe", sq.size() - sb, 0);
        chk("idle_done_npulse", pq.size() - pb, 0);
        chk("idle_done_busy", longint'(busy_out), 0);

        // Reset during EXEC aborts silently; next request is served normally.
        ch = int'($urandom_range(0, 3));
        rand_vals();
        drive_vals();
        resp_delay = 0;
        sb = sq.size(); pb = pq.size();
        usr_cmd_en_in = 4'(1 << ch);
        repeat (4) tick();
        chk("pre_reset_busy", longint'(busy_out), 1);
        reset = 1'b1;
        usr_cmd_en_in = 4'b0;
        tick();
        reset = 1'b0;
        chk_idle_outputs("mid_reset");
        repeat (TMO + HOLD + 6) tick();
        chk("mid_reset_nstrobe", sq.size() - sb, 1);
        chk("mid_reset_npulse", pq.size() - pb, 0);
        model_last = 0;
        rand_vals();
        run_batch(4'(1 << ch), int'($urandom_range(1, 8)), "post_reset");

        chk("one_hot_pulses", multi_hot, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
